uart_tx_serializer: RTL

- Byte-to-serial UART transmitter that sits directly downstream of the team's byte circular buffer (TX direction).
- Pops one byte at a time from the buffer's read side and shifts it out as an 8N1 (or 8N2) asynchronous frame on a single `tx` line.
- Buffer read port is combinational (data valid while not empty), so the pop and the data capture happen on the same edge.

---
 rtl/uart_tx_serializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter draining a byte circular buffer: pops one byte per frame
// and shifts it out as start + 8 data (LSB first) + STOP_BITS stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int STOP_BITS        = 1,
  parameter int BUFFER_BYTE_SIZE = 4,
  parameter int BUFFER_ADDR_SIZE = $clog2(BUFFER_BYTE_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_enable,
  input  logic [BUFFER_ADDR_SIZE:0] buf_avai,
  input  logic [7:0]                buf_data,
  output logic                      buf_read_en,
  output logic                      tx,
  output logic                      busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [BUFFER_ADDR_SIZE:0] EMPTY_AVAI = (BUFFER_ADDR_SIZE + 1)'(BUFFER_BYTE_SIZE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d, busy_d;
  logic             empty, bit_end;

  // Anything at or above capacity (including out-of-range counts) reads as empty.
  assign empty       = (buf_avai >= EMPTY_AVAI);
  assign bit_end     = (cnt == CNT_LAST);
  assign buf_read_en = (state == IDLE) & tx_enable & ~empty & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      tx    <= tx_d;
      busy  <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    tx_d    = tx;
    busy_d  = busy;
    if (state != IDLE) cnt_d = bit_end ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (buf_read_en) begin
          shift_d = buf_data;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (bit_end) begin
        idx_d   = '0;
        state_d = DATA;
        tx_d    = shift[0];
      end
      DATA: if (bit_end) begin
        shift_d = shift >> 1;
        if (idx == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx + 3'd1;
          tx_d  = shift[1];
        end
      end
      STOP: if (bit_end) begin
        // idx is reused to count stop bits
        if (idx == STOP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else begin
          idx_d = idx + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
